// File: rtl/stall_controller.sv
// stall_controller
//   Interlock for a 5-stage pipeline using a Tuse/Tnew scoreboard. A shadow
//   copy of the destination/Tnew fields of ID/EX and EX/MEM is kept here and
//   compared against the operands the ID instruction reads. A stall freezes
//   PC and IF/ID and loads a bubble into ID/EX.
//
//   Build option: define MD_STALL_EN to include the multiply/divide busy
//   counter. When it is left undefined, md_busy is tied low and the MD
//   inputs are ignored.
//
// Ports
//   clk           pipeline clock, rising edge
//   reset         asynchronous, active-high reset
//   id_valid      ID holds a real instruction (0 = bubble)
//   id_rs, id_rt  source registers read in ID
//   id_tuse_rs/rt cycles until operand is needed (3 = operand unused)
//   id_a3         destination register (0 = no write)
//   id_tnew       cycles after entering EX until result is forwardable
//   id_md_start   ID instruction starts a mult/multu/div/divu
//   id_md_div     qualifies id_md_start as a divide
//   id_uses_hilo  ID instruction touches HI/LO (mf/mt or MD start)
//   flush         synchronous flush of ID/EX and EX/MEM
//   stall         freeze PC and IF/ID
//   bubble_idex   load a nop into ID/EX on this edge
//   md_busy       multiply/divide unit occupied
module stall_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_tuse_rs,
  input  logic [1:0] id_tuse_rt,
  input  logic [4:0] id_a3,
  input  logic [1:0] id_tnew,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic       id_uses_hilo,
  input  logic       flush,
  output logic       stall,
  output logic       bubble_idex,
  output logic       md_busy
);

  logic [4:0] ex_a3;
  logic [1:0] ex_tnew;
  logic [4:0] mem_a3;
  logic [1:0] mem_tnew;

  logic haz_rs;
  logic haz_rt;
  logic md_haz;
  logic accept;

  // Register 0 and unused operands never interlock; a match only stalls when
  // the producer cannot forward in time (tuse < tnew).
  function automatic logic src_hazard(input logic [4:0] rs,
                                      input logic [1:0] tuse,
                                      input logic [4:0] ex_r,
                                      input logic [1:0] ex_t,
                                      input logic [4:0] mem_r,
                                      input logic [1:0] mem_t);
    logic hit;
    hit = 1'b0;
    if (rs != 5'd0 && tuse != 2'd3) begin
      if (rs == ex_r && tuse < ex_t)
        hit = 1'b1;
      if (rs == mem_r && tuse < mem_t)
        hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    haz_rs      = src_hazard(id_rs, id_tuse_rs, ex_a3, ex_tnew, mem_a3, mem_tnew);
    haz_rt      = src_hazard(id_rt, id_tuse_rt, ex_a3, ex_tnew, mem_a3, mem_tnew);
    stall       = (haz_rs | haz_rt | md_haz) & id_valid;
    bubble_idex = stall | flush;
    accept      = id_valid & ~stall & ~flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_a3    <= '0;
      ex_tnew  <= '0;
      mem_a3   <= '0;
      mem_tnew <= '0;
    end else begin
      if (accept) begin
        ex_a3   <= id_a3;
        ex_tnew <= id_tnew;
      end else begin
        ex_a3   <= '0;
        ex_tnew <= '0;
      end
      if (flush) begin
        mem_a3   <= '0;
        mem_tnew <= '0;
      end else begin
        mem_a3   <= ex_a3;
        mem_tnew <= (ex_tnew == 2'd0) ? 2'd0 : ex_tnew - 2'd1;
      end
    end
  end

`ifdef MD_STALL_EN
  logic [3:0] md_count;

  // A flush only blocks a new load (via accept); an operation already
  // running keeps counting down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_count <= '0;
    else if (accept && id_md_start)
      md_count <= id_md_div ? 4'd10 : 4'd5;
    else if (md_count != 4'd0)
      md_count <= md_count - 4'd1;
  end

  always_comb begin
    md_busy = (md_count != 4'd0);
    md_haz  = id_uses_hilo & md_busy;
  end
`else
  logic unused_md_inputs;

  always_comb begin
    md_busy          = 1'b0;
    md_haz           = 1'b0;
    unused_md_inputs = ^{id_md_start, id_md_div, id_uses_hilo};
  end
`endif

endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  pipeline clock, rising-edge.
REQ-003 reset  input  1  async active-high reset.
REQ-004 id_valid  input  1  ID stage holds a real instruction (0 = nop/bubble).
REQ-005 id_rs, id_rt  input  5 each  source register numbers read in ID.
REQ-006 id_tuse_rs, id_tuse_rt  input  2 each  cycles until operand needed (0 = ID use, 1 = EX, 2 = MEM, 3 = unused).
REQ-007 id_a3  input  5  destination register (0 = no write).
REQ-008 id_tnew  input  2  cycles after entering EX until result is forwardable (ALU = 1, load = 2, link = 0).
REQ-009 id_md_start  input  1  ID instruction is mult/multu/div/divu.
REQ-010 id_md_div  input  1  qualifies id_md_start as divide.
REQ-011 id_uses_hilo  input  1  ID instruction is mfhi/mflo/mthi/mtlo or an MD start.
REQ-012 flush  input  1  synchronous exception/eret flush of ID/EX and EX/MEM.
REQ-013 stall  output  1  freeze PC and IF/ID.
REQ-014 bubble_idex  output  1  load nop into ID/EX this edge.
REQ-015 md_busy  output  1  multiply/divide unit occupied.

Function
REQ-016 SHALL keep a shadow scoreboard of two entries, EX and MEM, each {a3[4:0], tnew[1:0]}, mirroring ID/EX and EX/MEM.
REQ-017 On each edge: EX <= {id_a3, id_tnew} if id_valid & ~stall & ~flush, else {0,0}; MEM <= {EX.a3, EX.tnew-1 saturating at 0}, or {0,0} if flush.
REQ-018 Data hazard on rs SHALL be asserted when id_rs!=0, id_tuse_rs!=3, and (id_rs==EX.a3 & id_tuse_rs<EX.tnew) or (id_rs==MEM.a3 & id_tuse_rs<MEM.tnew); same for rt.
REQ-019 stall SHALL be combinational, same cycle: (rs hazard | rt hazard | md hazard) & id_valid.
REQ-020 bubble_idex SHALL equal stall | flush.
REQ-021 When tnew satisfies tuse (no stall), forwarding is handled elsewhere; this block SHALL NOT stall on a match with tnew<=tuse.
REQ-022 MD counter (4 bit): when an MD start is accepted into EX (id_md_start & id_valid & ~stall & ~flush), SHALL load 5 (mult) or 10 (div) on that edge; otherwise decrement if nonzero.
REQ-023 md_busy SHALL equal (counter!=0).
REQ-024 md hazard SHALL equal id_uses_hilo & md_busy.
REQ-025 flush SHALL NOT cancel a running MD counter; it only prevents a new load.
REQ-026 Hazard on both rs and rt plus md hazard in the same cycle SHALL yield a single stall; stall holds until all clear.
REQ-027 id_a3==0 entries SHALL never cause a stall (register 0 is never a hazard).

Reset
REQ-028 On reset: EX and MEM entries {0,0}, MD counter 0; hence stall=0, bubble_idex=0, md_busy=0 while reset is high.
REQ-029 Reset asserted mid-MD operation SHALL clear md_busy immediately (asynchronously).

Configuration
REQ-030 Macro MD_STALL_EN: defined -> MD counter, md_busy and md hazard per REQ-022..025; undefined -> no counter, md_busy tied 0, md hazard 0, id_md_start/id_md_div/id_uses_hilo ignored.

Verification
REQ-031 lw $8 (a3=8, tnew=2) enters EX, ID holds add using $8 (tuse_rs=1) -> stall=1, bubble_idex=1 for exactly 1 cycle, then 0.
REQ-032 lw $8 then beq using $8 (tuse=0) -> stall for 2 cycles; addu $8 then beq $8 -> stall 1 cycle; addu $8 then sw data $8 (tuse_rt=2) -> no stall.
REQ-033 addu $0 then add using $0 -> stall=0 throughout.
REQ-034 With MD_STALL_EN: div accepted, next instr mflo -> md_busy=1 for 10 cycles, stall=1 until counter reaches 0, mflo proceeds the following cycle; mult -> 5 cycles.
REQ-035 lw $8 in EX, flush=1 same cycle as stalled consumer -> next cycle EX/MEM entries zero, stall=0; running div counter keeps counting.
REQ-036 Assert reset while counter=7 and EX holds load -> md_busy, stall drop to 0 before next clk edge; without MD_STALL_EN, div followed by mflo -> no stall.
